// File: rtl/add_accum_pkg.sv
// Shared types and helpers for the add_accum32 accumulator.
package add_accum_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Increment val by one when en is set, holding at max_val instead of wrapping.
  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] val,
                                                input logic [WORD_W-1:0] max_val,
                                                input logic              en);
    logic [WORD_W-1:0] res;
    res = val;
    if (en && (val != max_val)) begin
      res = val + WORD_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/add_accum32_if.sv
// Operand-stream and result handshake bundle for add_accum32.
interface add_accum32_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = 16
);
  import add_accum_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_sum;
  logic [CNT_W-1:0]  out_carries;
  logic [LEN_W-1:0]  out_len;
  logic              busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carries, out_len, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carries, out_len, busy
  );

endinterface

// File: rtl/carry_skip_32bit.sv
// 32-bit carry-skip adder: 4-bit ripple blocks, carry bypasses a block whose bits all propagate.
module carry_skip_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int unsigned BLK_W = 4;
  localparam int unsigned N_BLK = 8;

  logic c;
  logic c_blk;
  logic blk_p;
  logic p_bit;

  always_comb begin
    c     = cin;
    c_blk = 1'b0;
    blk_p = 1'b0;
    p_bit = 1'b0;
    sum   = '0;
    for (int unsigned blk = 0; blk < N_BLK; blk++) begin
      c_blk = c;
      blk_p = 1'b1;
      for (int unsigned i = 0; i < BLK_W; i++) begin
        p_bit              = a[blk*BLK_W+i] ^ b[blk*BLK_W+i];
        sum[blk*BLK_W+i]   = p_bit ^ c;
        c                  = (a[blk*BLK_W+i] & b[blk*BLK_W+i]) | (p_bit & c);
        blk_p              = blk_p & p_bit;
      end
      // Full-propagate block forwards its incoming carry directly.
      if (blk_p) begin
        c = c_blk;
      end
    end
    cout = c;
  end

endmodule

// File: rtl/add_accum32.sv
// Streaming multi-operand accumulator around carry_skip_32bit.
// ACC_SAT_EN: when defined, acc clamps to all-ones on adder carry-out instead of wrapping.
module add_accum32
  import add_accum_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  add_accum32_if.slave bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  carries_q, carries_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0]  out_carries_q, out_carries_d;
  logic [LEN_W-1:0]  out_len_q, out_len_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic [WORD_W-1:0] add_sum_c;
  logic              add_cout_c;
  logic [WORD_W-1:0] acc_nxt_c;
  logic [CNT_W-1:0]  carries_nxt_c;
  logic [LEN_W-1:0]  len_nxt_c;
  logic              accept_c;
  logic              out_hs_c;

  carry_skip_32bit u_adder (
    .a    (acc_q),
    .b    (bus.in_data),
    .cin  (1'b0),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  assign accept_c = bus.in_valid & in_ready_q;
  assign out_hs_c = out_valid_q & bus.out_ready;

  // Next acc value for an accepted beat; the only build-dependent logic.
  always_comb begin
`ifdef ACC_SAT_EN
    acc_nxt_c = add_cout_c ? {WORD_W{1'b1}} : add_sum_c;
`else
    acc_nxt_c = add_sum_c;
`endif
    carries_nxt_c = CNT_W'(sat_inc(WORD_W'(carries_q), WORD_W'({CNT_W{1'b1}}), add_cout_c));
    len_nxt_c     = LEN_W'(sat_inc(WORD_W'(len_q), WORD_W'({LEN_W{1'b1}}), 1'b1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept_c) begin
          state_d = bus.in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_hs_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    acc_d         = acc_q;
    carries_d     = carries_q;
    len_d         = len_q;
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    out_carries_d = out_carries_q;
    out_len_d     = out_len_q;
    if ((state_q != DONE) && accept_c) begin
      acc_d     = acc_nxt_c;
      carries_d = carries_nxt_c;
      len_d     = len_nxt_c;
      if (bus.in_last) begin
        out_valid_d   = 1'b1;
        out_sum_d     = acc_nxt_c;
        out_carries_d = carries_nxt_c;
        out_len_d     = len_nxt_c;
      end
    end else if ((state_q == DONE) && out_hs_c) begin
      out_valid_d = 1'b0;
      acc_d       = '0;
      carries_d   = '0;
      len_d       = '0;
    end
    in_ready_d = (state_d != DONE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q         <= '0;
      carries_q     <= '0;
      len_q         <= '0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
      out_carries_q <= '0;
      out_len_q     <= '0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      carries_q     <= carries_d;
      len_q         <= len_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_carries_q <= out_carries_d;
      out_len_q     <= out_len_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sum     = out_sum_q;
  assign bus.out_carries = out_carries_q;
  assign bus.out_len     = out_len_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_add_accum32.sv
// Scoreboard bench for add_accum32: a bench-side model pushes expected results per burst.
module tb_add_accum32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  add_accum32_if #(.CNT_W(8), .LEN_W(16)) bus ();

  add_accum32 #(.CNT_W(8), .LEN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic [7:0]  car;
    logic [15:0] len;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_acc;
  logic [7:0]  m_car;
  logic [15:0] m_len;

  task automatic model_clear();
    m_acc = '0;
    m_car = '0;
    m_len = '0;
  endtask

  // Drive one beat for one clock and advance the reference model.
  task automatic send_beat(input logic [31:0] d, input logic last);
    logic [32:0] s;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    s = {1'b0, m_acc} + {1'b0, d};
    if (s[32] && (m_car != 8'hFF)) m_car = m_car + 8'd1;
`ifdef ACC_SAT_EN
    m_acc = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
    m_acc = s[31:0];
`endif
    if (m_len != 16'hFFFF) m_len = m_len + 16'd1;
    if (last) begin
      sb.push_back('{sum: m_acc, car: m_car, len: m_len});
      model_clear();
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e  = '0;
    if (ok) e = sb.pop_front();
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum got %h want 0", bus.out_sum); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.out_len !== 16'h0 || bus.out_carries !== 8'h0) begin errors++; $display("FAIL reset_counts got len %h car %h want 0 0", bus.out_len, bus.out_carries); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_burst();
    exp_t e; bit ok;
    send_beat(32'h0000_001F, 1'b0);
    checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_acc_state got busy %b rdy %b want 1 1", bus.busy, bus.in_ready); end
    send_beat(32'h0000_000C, 1'b0);
    send_beat(32'h0000_0001, 1'b1);
    pop_exp(e, ok);
    checks++; if (bus.out_valid !== 1'b1 || !ok) begin errors++; $display("FAIL basic_valid got %b want 1 (sb %0d)", bus.out_valid, ok); end
    checks++; if (bus.out_sum !== e.sum) begin errors++; $display("FAIL basic_sum got %h want %h", bus.out_sum, e.sum); end
    checks++; if (bus.out_carries !== e.car || bus.out_len !== e.len) begin errors++; $display("FAIL basic_counts got car %h len %h want %h %h", bus.out_carries, bus.out_len, e.car, e.len); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_ready got %b want 0", bus.in_ready); end
    consume();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_after_hs got v %b rdy %b busy %b want 0 1 0", bus.out_valid, bus.in_ready, bus.busy); end
  endtask

  task automatic test_overflow();
    exp_t e; bit ok;
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'h0000_0001, 1'b1);
    pop_exp(e, ok);
    checks++; if (bus.out_valid !== 1'b1 || !ok) begin errors++; $display("FAIL ovf_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_sum !== e.sum) begin errors++; $display("FAIL ovf_sum got %h want %h", bus.out_sum, e.sum); end
    checks++; if (bus.out_carries !== e.car || bus.out_len !== e.len) begin errors++; $display("FAIL ovf_counts got car %h len %h want %h %h", bus.out_carries, bus.out_len, e.car, e.len); end
    consume();
  endtask

  task automatic test_backpressure();
    exp_t e; bit ok;
    send_beat(32'h0000_0003, 1'b0);
    send_beat(32'h0000_0004, 1'b1);
    pop_exp(e, ok);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0100;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== e.sum || bus.out_len !== e.len || !ok) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v %b rdy %b sum %h len %h want 1 0 %h %h", i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_len, e.sum, e.len);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    consume();
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v %b busy %b rdy %b want 0 0 1", bus.out_valid, bus.busy, bus.in_ready); end
    send_beat(32'h0000_0007, 1'b1);
    pop_exp(e, ok);
    checks++; if (bus.out_sum !== e.sum || bus.out_len !== e.len || !ok) begin errors++; $display("FAIL bp_no_consume got sum %h len %h want %h %h", bus.out_sum, bus.out_len, e.sum, e.len); end
    consume();
  endtask

  task automatic test_single_beat();
    exp_t e; bit ok;
    send_beat(32'h8000_0000, 1'b1);
    pop_exp(e, ok);
    checks++; if (bus.out_valid !== 1'b1 || !ok) begin errors++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_sum !== e.sum || bus.out_len !== e.len || bus.out_carries !== e.car) begin errors++; $display("FAIL single_result got sum %h len %h car %h want %h %h %h", bus.out_sum, bus.out_len, bus.out_carries, e.sum, e.len, e.car); end
    consume();
  endtask

  task automatic test_reset_mid();
    exp_t e; bit ok;
    send_beat(32'h0000_0010, 1'b0);
    send_beat(32'h0000_0020, 1'b0);
    model_clear();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state got v %b busy %b rdy %b want 0 0 1", bus.out_valid, bus.busy, bus.in_ready); end
    send_beat(32'h0000_0005, 1'b1);
    pop_exp(e, ok);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_len !== e.len || !ok) begin errors++; $display("FAIL rstmid_result got v %b sum %h len %h want 1 %h %h", bus.out_valid, bus.out_sum, bus.out_len, e.sum, e.len); end
    // Reset with a result pending drops it.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0) begin errors++; $display("FAIL rstmid_pending got v %b sum %h want 0 0", bus.out_valid, bus.out_sum); end
  endtask

  task automatic test_carry_sat();
    exp_t e; bit ok;
    for (int i = 0; i < 300; i++) send_beat(32'hFFFF_FFFF, (i == 299));
    pop_exp(e, ok);
    checks++; if (bus.out_valid !== 1'b1 || !ok) begin errors++; $display("FAIL csat_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_carries !== e.car || bus.out_len !== e.len || bus.out_sum !== e.sum) begin errors++; $display("FAIL csat_result got car %h len %h sum %h want %h %h %h", bus.out_carries, bus.out_len, bus.out_sum, e.car, e.len, e.sum); end
    consume();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic_burst();
    test_overflow();
    test_backpressure();
    test_single_beat();
    test_reset_mid();
    test_carry_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_accum32.md
# add_accum32

Sequential multi-operand accumulator that drives the 32-bit carry-skip adder (`carry_skip_32bit`) with a running sum and streamed operands. It sits directly upstream of the adder and also captures the adder's result. Operands arrive as valid/ready bursts, one beat per cycle. Each beat is added into a registered accumulator. On the last beat, the total, the carry-out count and the beat count are presented on a registered output handshake.

## Interface
- `CNT_W`, 8: width of the carry-out counter `out_carries`; saturating.
- `LEN_W`, 16: width of the beat counter `out_len`; saturating.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  32  operand, unsigned.
- `in_last`  in  1  marks final beat of burst; qualified by `in_valid & in_ready`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  32  accumulated sum.
- `out_carries`  out  CNT_W  number of beats whose add produced `cout=1`.
- `out_len`  out  LEN_W  beats in burst.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE: accumulator, carry count and length are all 0.
  - ACC: at least one beat has been accepted.
  - DONE: result is held on the output.
- Beat accept condition: `in_valid & in_ready`.
- `in_ready`:
  - 1 in IDLE and ACC; 0 in DONE.
  - Decoded from state only; no combinational path from `in_valid`.
- On accept:
  - Adder inputs are `a=acc`, `b=in_data`, `cin=0`.
  - `acc <= sum`.
  - `carries <= carries + cout`, saturating at all-ones.
  - `len <= len + 1`, saturating at all-ones.
- Transitions:
  - Accept without `in_last`: IDLE→ACC, or ACC→ACC.
  - Accept with `in_last`: →DONE. The updated acc, carries and len are loaded into the output registers, and `out_valid` is set.
- DONE:
  - `in_valid` is ignored.
  - Outputs stay stable until `out_valid & out_ready`.
  - On that handshake: `out_valid <= 0`, internal counters clear, →IDLE.
- Single-beat burst (`in_last` on the first beat): IDLE→DONE. Result is `in_data`, `out_len=1`, `out_carries=0`.
- Reset mid-operation (`rst_n` low at any edge):
  - Partial burst and any pending result are discarded; state →IDLE.
  - `out_valid` is not asserted for the dropped burst.
- Reset values: `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_carries=0`, `out_len=0`, `busy=0`.

## Timing
- Throughput: one beat per cycle within a burst.
- The adder is a single-cycle combinational path from the `acc` register, through `carry_skip_32bit`, to the `acc` register. It must close timing at the target clock.
- Latency: last beat accepted at edge N → `out_valid=1` after edge N.
- Inter-burst gap: at least one cycle. `in_ready` returns 1 on the cycle after the output handshake.
- `out_*` are registered. There is no combinational path from any input to `out_valid`, `out_sum`, `out_carries`, `out_len` or `in_ready`.

## Configuration
- `ACC_SAT_EN`, defined:
  - When a beat's add yields `cout=1`, `acc` clamps to 32'hFFFFFFFF instead of taking `sum`.
  - Once saturated, `acc` remains saturated for the rest of the burst.
  - `carries` still counts every `cout`.
- `ACC_SAT_EN`, undefined: `acc` wraps modulo 2^32; `carries` records the wraps.
- The macro changes only the `acc` next-value selection. The interface is identical in both builds.

## Structure
- Package `add_accum_pkg`:
  - `WORD_W=32`.
  - State enum: IDLE, ACC, DONE.
  - Saturating-increment function used by both counters.
- Exactly one sub-module instance: `carry_skip_32bit`, unmodified, with `cin` tied to 0.
- All control (FSM, counters, output registers) lives in `add_accum32`.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles → `in_ready=1`, `out_valid=0`, `out_sum=0`, `busy=0`.
- Burst of 0x0000001F, 0x0000000C, 0x00000001(last), back-to-back → one cycle after the last beat: `out_sum=0x0000002C`, `out_carries=0`, `out_len=3`.
- Burst of 0xFFFFFFFF, 0x00000001(last):
  - Without `ACC_SAT_EN` → `out_sum=0x00000000`, `out_carries=1`.
  - With `ACC_SAT_EN` → `out_sum=0xFFFFFFFF`, `out_carries=1`; `out_len=2` in both builds.
- Backpressure: result pending, `out_ready=0` for 5 cycles while `in_valid=1` → outputs stable, `in_ready=0`, no beat consumed. `out_ready=1` → IDLE next cycle.
- Single beat 0x80000000 with `in_last` → next cycle `out_sum=0x80000000`, `out_len=1`, `out_carries=0`.
- Reset mid-burst: accept 0x10 and 0x20, pulse `rst_n=0` for one cycle, then send 0x05(last) → `out_sum=0x00000005`, `out_len=1`.
